// File: rtl/dma_read_scheduler.sv
// Splits one host-memory read job into MRd requests bounded by the max read size and 4 KB
// pages, issues them one at a time to the TX engine and throttles on outstanding reads.
module dma_read_scheduler #(
  parameter int unsigned P_MAX_RD_DW       = 128,
  parameter int unsigned P_MAX_OUTSTANDING = 8,
  parameter int unsigned P_OUT_BITS        = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           job_addr_i,
  input  logic [15:0]           job_len_dw_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  output logic                  job_done_o,
  output logic [31:0]           dma_read_addr_o,
  output logic [9:0]            dma_read_len_o,
  output logic                  dma_read_valid_o,
  input  logic                  dma_read_done_i,
  input  logic [7:0]            current_tag_i,
  output logic [7:0]            issued_tag_o,
  output logic                  issued_tag_valid_o,
  input  logic                  cpl_release_i,
  output logic [P_OUT_BITS-1:0] outstanding_o,
  output logic                  err_release_o
);

  localparam logic [15:0]           MaxRdDw = 16'(P_MAX_RD_DW);
  localparam logic [P_OUT_BITS-1:0] MaxOut  = P_OUT_BITS'(P_MAX_OUTSTANDING);
  localparam logic [P_OUT_BITS-1:0] OutOne  = P_OUT_BITS'(1);

  typedef enum logic [2:0] {StIdle, StCalc, StIssue, StDrain, StDone} state_e;

  state_e                state_q;
  logic [31:0]           cur_addr_q;
  logic [15:0]           rem_dw_q;
  logic                  job_ready_q;
  logic                  job_done_q;
  logic [31:0]           addr_q;
  logic [9:0]            len_q;
  logic                  valid_q;
  logic [7:0]            issued_tag_q;
  logic                  issued_tag_valid_q;
  logic [P_OUT_BITS-1:0] out_q, out_d;
  logic                  err_q, err_d;

  logic [12:0] dist_dw;
  logic [15:0] chunk;
  logic [15:0] rem_after;
  logic        issue;
  logic        unused_bits;

  // DW remaining before the next 4 KB page boundary; always 1..1024 for a DW-aligned address.
  assign dist_dw   = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> 2;
  assign rem_after = rem_dw_q - {6'b0, len_q};
  assign issue     = (state_q == StIssue) && dma_read_done_i;

  always_comb begin
    chunk = rem_dw_q;
    if (chunk > MaxRdDw) chunk = MaxRdDw;
    if (chunk > {3'b0, dist_dw}) chunk = {3'b0, dist_dw};
  end

  // Issue and release in the same cycle cancel; a release with nothing outstanding is an error.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (issue && !cpl_release_i) begin
      out_d = out_q + OutOne;
    end else if (!issue && cpl_release_i) begin
      if (out_q == '0) err_d = 1'b1;
      else             out_d = out_q - OutOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q            <= StIdle;
      cur_addr_q         <= '0;
      rem_dw_q           <= '0;
      job_ready_q        <= 1'b1;
      job_done_q         <= 1'b0;
      addr_q             <= '0;
      len_q              <= '0;
      valid_q            <= 1'b0;
      issued_tag_q       <= '0;
      issued_tag_valid_q <= 1'b0;
      out_q              <= '0;
      err_q              <= 1'b0;
    end else begin
      issued_tag_valid_q <= 1'b0;
      job_done_q         <= 1'b0;
      out_q              <= out_d;
      err_q              <= err_d;
      unique case (state_q)
        StIdle: begin
          if (job_valid_i && job_ready_q) begin
            cur_addr_q  <= {job_addr_i[31:2], 2'b00};
            rem_dw_q    <= job_len_dw_i;
            job_ready_q <= 1'b0;
            state_q     <= (job_len_dw_i == '0) ? StDone : StCalc;
          end
        end
        StCalc: begin
          addr_q <= cur_addr_q;
          len_q  <= chunk[9:0];
          if (out_q < MaxOut) begin
            valid_q <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (dma_read_done_i) begin
            // Drop valid for a cycle so the engine never sees the same request twice.
            valid_q            <= 1'b0;
            issued_tag_q       <= current_tag_i - 8'd1;
            issued_tag_valid_q <= 1'b1;
            cur_addr_q         <= cur_addr_q + {20'b0, len_q, 2'b00};
            rem_dw_q           <= rem_after;
            state_q            <= (rem_after == '0) ? StDrain : StCalc;
          end
        end
        StDrain: begin
          if (out_q == '0) state_q <= StDone;
        end
        StDone: begin
          job_done_q  <= 1'b1;
          job_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign unused_bits = ^{job_addr_i[1:0], chunk[15:10]};

  assign job_ready_o        = job_ready_q;
  assign job_done_o         = job_done_q;
  assign dma_read_addr_o    = addr_q;
  assign dma_read_len_o     = len_q;
  assign dma_read_valid_o   = valid_q;
  assign issued_tag_o       = issued_tag_q;
  assign issued_tag_valid_o = issued_tag_valid_q;
  assign outstanding_o      = out_q;
  assign err_release_o      = err_q;

endmodule
